fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/mips_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_queue.sv | 95 +++++++++
 tb/tb_fetch_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS front end.
// Declares the default program-counter width, the instruction-memory word-address
// width, the instruction width and the prefetch queue depth used by fetch_queue.
package mips_pkg;

   localparam int PC_WIDTH       = 6;
   localparam int CODE_DIR_WIDTH = 4;
   localparam int INSTR_WIDTH    = 32;
   localparam int FIFO_DEPTH     = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO that holds prefetched {PC+4, instruction} entries.
// Ports:
//   clk, rst    - rising-edge clock, asynchronous active-low reset
//   flush       - drop every entry (wins over push and pop)
//   push, wdata - write an entry at the tail
//   pop         - advance the head (ignored when empty)
//   rdata       - head entry, reads 0 when empty
//   count       - number of stored entries
//   valid       - head holds an entry
module fetch_fifo #(
   parameter  int WIDTH = 38,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             valid
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign valid   = (count != '0);
   assign do_pop  = pop && valid;
   // A push into a full queue is only legal when the head leaves on the same edge.
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; entries are only observed while count says so.
   always_ff @(posedge clk) begin
      if (!flush && do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage with a small prefetch queue.
// Issues one instruction-memory read per cycle while queue credit remains, captures
// the response one cycle later and presents the queue head to IF/ID.
// Ports:
//   clk, rst                     - rising-edge clock, asynchronous active-low reset
//   branch_taken, branch_target  - redirect from EX/MEM, highest priority
//   stall                        - IF/ID not accepting the head this cycle
//   imem_req, imem_addr          - fetch request and word address
//   imem_rdata                   - instruction word, valid the cycle after imem_req
//   out_valid, Instruction       - queue head and its valid flag
//   PCnext                       - fetch PC + 4 of the head instruction
//   PCout                        - current fetch PC register
module fetch_queue
   import mips_pkg::INSTR_WIDTH;
#(
   parameter int PC_WIDTH       = mips_pkg::PC_WIDTH,
   parameter int CODE_DIR_WIDTH = mips_pkg::CODE_DIR_WIDTH,
   parameter int FIFO_DEPTH     = mips_pkg::FIFO_DEPTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      branch_taken,
   input  logic [PC_WIDTH-1:0]       branch_target,
   input  logic                      stall,
   output logic                      imem_req,
   output logic [CODE_DIR_WIDTH-1:0] imem_addr,
   input  logic [INSTR_WIDTH-1:0]    imem_rdata,
   output logic                      out_valid,
   output logic [INSTR_WIDTH-1:0]    Instruction,
   output logic [PC_WIDTH-1:0]       PCnext,
   output logic [PC_WIDTH-1:0]       PCout
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int EW = PC_WIDTH + INSTR_WIDTH;

   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] pc_plus4;
   logic [PC_WIDTH-1:0] tag;
   logic                inflight;
   logic [CW-1:0]       count;
   logic [CW:0]         credit;
   logic                pop;
   logic                push;
   logic [EW-1:0]       head;

   assign pc_plus4 = pc + PC_WIDTH'(4);
   assign pop      = out_valid && !stall;
   assign push     = inflight && !branch_taken;

   // Occupancy after this edge if nothing new were issued; an issue is allowed only
   // while this leaves room for the response it will produce next cycle.
   assign credit   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
   assign imem_req = rst && !branch_taken && (credit < (CW + 1)'(FIFO_DEPTH));
   assign imem_addr = pc[CODE_DIR_WIDTH+1:2];
   assign PCout     = pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc       <= '0;
         inflight <= 1'b0;
         tag      <= '0;
      end else if (branch_taken) begin
         // The response arriving this cycle belongs to the old path and is dropped.
         pc       <= branch_target & ~PC_WIDTH'(3);
         inflight <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            pc  <= pc_plus4;
            tag <= pc_plus4;
         end
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (branch_taken),
      .push  (push),
      .pop   (pop),
      .wdata ({tag, imem_rdata}),
      .rdata (head),
      .count (count),
      .valid (out_valid)
   );

   // The FIFO already returns zero when empty.
   assign Instruction = head[INSTR_WIDTH-1:0];
   assign PCnext      = head[EW-1:INSTR_WIDTH];

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        branch_taken = 1'b0;
   logic [5:0]  branch_target = '0;
   logic        stall = 1'b0;
   logic        imem_req;
   logic [3:0]  imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        out_valid;
   logic [31:0] Instruction;
   logic [5:0]  PCnext;
   logic [5:0]  PCout;

   int n_chk  = 0;
   int n_fail = 0;
   int pops   = 0;

   logic [37:0] sb [$];
   logic [3:0]  exp_addr = '0;

   fetch_queue dut (
      .clk           (clk),
      .rst           (rst),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .stall         (stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .out_valid     (out_valid),
      .Instruction   (Instruction),
      .PCnext        (PCnext),
      .PCout         (PCout)
   );

   always #5 clk = ~clk;

   // ROM: word n = 0x1000_0000 + n, returned the cycle after the request.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= 32'h1000_0000 + {28'd0, imem_addr};
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard: each issued fetch is queued with its expected {PC+4, word};
   // redirect and reset discard everything outstanding.
   always @(negedge clk) begin
      logic [37:0] e;
      logic [5:0]  t;
      if (!rst) begin
         sb.delete();
         exp_addr <= '0;
      end else if (branch_taken) begin
         chk("req_during_branch", imem_req, 0);
         sb.delete();
         exp_addr <= branch_target[5:2];
      end else begin
         if (!out_valid) begin
            chk("idle_instr_zero", Instruction, 0);
            chk("idle_pcnext_zero", PCnext, 0);
         end
         if (out_valid && !stall) begin
            if (sb.size() == 0) begin
               chk("pop_without_expected", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("sb_instr", Instruction, e[31:0]);
               chk("sb_pcnext", PCnext, e[37:32]);
               pops <= pops + 1;
            end
         end
         if (imem_req) begin
            chk("fetch_addr", imem_addr, exp_addr);
            t = {exp_addr, 2'b00} + 6'd4;
            sb.push_back({t, 32'h1000_0000 + {28'd0, exp_addr}});
            exp_addr <= exp_addr + 4'd1;
         end
      end
   end

   initial begin
      bit found;
      #1 rst = 1'b0;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_instr", Instruction, 0);
      chk("rst_pcnext", PCnext, 0);
      chk("rst_pcout", PCout, 0);
      chk("rst_imem_req", imem_req, 0);
      step(2);
      rst = 1'b1;
      #1;
      chk("first_req", imem_req, 1);
      chk("first_addr", imem_addr, 0);
      chk("first_valid", out_valid, 0);
      step(1);
      chk("edge1_addr", imem_addr, 1);
      chk("edge1_pcout", PCout, 4);
      chk("edge1_valid", out_valid, 0);
      step(1);
      chk("edge2_valid", out_valid, 1);
      chk("edge2_instr", Instruction, 32'h1000_0000);
      chk("edge2_pcnext", PCnext, 4);

      // Run sequentially until the PC reaches the top of the address space.
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (PCout == 6'h3C) found = 1;
         else step(1);
      end
      chk("reach_3c", found, 1);
      chk("addr_15", imem_addr, 15);
      chk("req_at_3c", imem_req, 1);
      step(1);
      chk("wrap_pcout", PCout, 0);
      chk("wrap_addr", imem_addr, 0);

      // Stall for five cycles mid-stream.
      step(3);
      stall = 1'b1;
      #1;
      chk("stall_req_drop", imem_req, 0);
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("stall_req", imem_req, 0);
         chk("stall_valid", out_valid, 1);
         chk("stall_head", Instruction, (sb.size() > 0) ? {32'd0, sb[0][31:0]} : 64'hDEAD);
      end
      stall = 1'b0;

      // Redirect, stall and an in-flight response on the same edge.
      step(4);
      stall = 1'b1;
      branch_taken = 1'b1;
      branch_target = 6'h24;
      #1;
      chk("br_req_low", imem_req, 0);
      step(1);
      branch_taken = 1'b0;
      stall = 1'b0;
      #1;
      chk("br_valid_low", out_valid, 0);
      chk("br_pcout", PCout, 6'h24);
      chk("br_req", imem_req, 1);
      chk("br_addr", imem_addr, 9);
      step(1);
      chk("br_valid_still_low", out_valid, 0);
      step(1);
      chk("br_valid", out_valid, 1);
      chk("br_instr", Instruction, 32'h1000_0009);
      chk("br_pcnext", PCnext, 6'h28);

      // Redirect to an unaligned target while the queue is full.
      stall = 1'b1;
      step(3);
      chk("full_req_low", imem_req, 0);
      branch_taken = 1'b1;
      branch_target = 6'h31;
      step(1);
      branch_taken = 1'b0;
      stall = 1'b0;
      #1;
      chk("br2_pcout", PCout, 6'h30);
      chk("br2_addr", imem_addr, 12);
      chk("br2_valid", out_valid, 0);
      step(2);
      chk("br2_instr", Instruction, 32'h1000_000C);
      chk("br2_pcnext", PCnext, 6'h34);

      // Reset mid-stream with the queue full.
      step(4);
      stall = 1'b1;
      step(3);
      chk("pre_rst_valid", out_valid, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_instr", Instruction, 0);
      chk("mid_rst_pcnext", PCnext, 0);
      chk("mid_rst_pcout", PCout, 0);
      chk("mid_rst_req", imem_req, 0);
      step(1);
      rst = 1'b1;
      stall = 1'b0;
      #1;
      chk("post_rst_req", imem_req, 1);
      chk("post_rst_addr", imem_addr, 0);
      step(2);
      chk("post_rst_instr", Instruction, 32'h1000_0000);
      chk("post_rst_pcnext", PCnext, 4);

      step(30);
      chk("enough_pops", pops >= 30, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
